// File: rtl/pipelined_fir.sv
// pipelined_fir: 3-stage transposed-form FIR, one sample in and one full-precision result out per clock (optional clock enable via FIR_CE_EN)
module pipelined_fir #(
  parameter int NTAPS = 16,
  parameter int DIN_W = 16,
  parameter int COEF_W = 16,
  parameter int DOUT_W = 64,
  parameter logic [NTAPS*COEF_W-1:0] COEFFS = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                                               16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef FIR_CE_EN
  input  logic                     ce,
`endif
  input  logic signed [DIN_W-1:0]  din,
  output logic signed [DOUT_W-1:0] dout
);
  localparam int PW = COEF_W + DIN_W;
  logic                     w_ce;
  logic signed [DIN_W-1:0]  r_x;
  logic signed [PW-1:0]     r_p [NTAPS];
  logic signed [DOUT_W-1:0] r_acc [NTAPS];
  logic signed [DOUT_W-1:0] r_dout;
`ifdef FIR_CE_EN
  assign w_ce = ce;
`else
  assign w_ce = 1'b1;
`endif
  // input sample register and output register behind the accumulator chain
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_x    <= '0;
      r_dout <= '0;
    end else if (w_ce) begin
      r_x    <= din;
      r_dout <= r_acc[0];
    end
  genvar k;
  for (k = 0; k < NTAPS; k++) begin : g_tap
    logic signed [COEF_W-1:0] w_h;
    logic signed [DOUT_W-1:0] w_pext;
    logic signed [DOUT_W-1:0] w_up;
    assign w_h    = COEFFS[k*COEF_W +: COEF_W];
    assign w_pext = DOUT_W'(r_p[k]);
    if (k == NTAPS - 1) begin : g_last
      assign w_up = '0;
    end else begin : g_mid
      assign w_up = r_acc[k+1];
    end
    // per-tap product register and transposed accumulator stage
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_p[k]   <= '0;
        r_acc[k] <= '0;
      end else if (w_ce) begin
        r_p[k]   <= PW'(w_h) * PW'(r_x);
        r_acc[k] <= w_up + w_pext;
      end
  end
  assign dout = r_dout;
endmodule

// File: tb/tb_pipelined_fir.sv
// tb_pipelined_fir: scoreboard bench for pipelined_fir (exercises ce when FIR_CE_EN is defined)
module tb_pipelined_fir;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [15:0] din = '0;
  logic signed [63:0] dout;
`ifdef FIR_CE_EN
  logic ce = 1'b1;
`endif

  pipelined_fir dut (
    .clk(clk),
    .rst(rst),
`ifdef FIR_CE_EN
    .ce(ce),
`endif
    .din(din),
    .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     chk;
    longint v;
    string  tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int h[16]   = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};
  int stp[16] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 51, 57, 62, 66, 69, 71, 72};

  task automatic check(input string tag, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: dout=%0d expected=%0d", tag, act, expv);
    end
  endtask

  // monitor: the DUT presents a result after every edge; compare it to the oldest expectation
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) check(e.tag, dout, e.v);
      end
    end
  end

  // drive one sample before the next edge and queue what dout must be after that edge
  task automatic push(input logic signed [15:0] x, input bit chk, input longint v, input string tag);
    @(negedge clk);
    rst = 1'b1;
    din = x;
    q.push_back(exp_t'{chk, v, tag});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    din = 16'sd0;
    #1 check("reset_clear", dout, 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic longint step_exp(input int a, input int i);
    int j;
    if (i < 3) return 0;
    j = (i - 3 > 15) ? 15 : i - 3;
    return longint'(a) * longint'(stp[j]);
  endfunction

  function automatic longint imp_exp(input int a, input int i);
    if (i < 3 || i > 18) return 0;
    return longint'(a) * longint'(h[i-3]);
  endfunction

  task automatic impulse(input int a, input string tag);
    for (int i = 0; i < 24; i++) push((i == 0) ? 16'(a) : 16'sd0, 1'b1, imp_exp(a, i), tag);
  endtask

  task automatic step(input int a, input int n, input string tag);
    for (int i = 0; i < n; i++) push(16'(a), 1'b1, step_exp(a, i), tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", dout, 0);
    impulse(1, "impulse");
    reset_dut();
    step(1, 24, "step");
    reset_dut();
    step(32767, 22, "step_max");
    @(posedge clk);
    #2 check("max_settle", dout, 2359224);
    reset_dut();
    impulse(-32768, "impulse_min");
    reset_dut();
    for (int i = 0; i < 40; i++) push((i % 2 == 0) ? 16'sd100 : -16'sd100, i >= 19, 0, "alternating");
    reset_dut();
    step(1000, 10, "step_pre_reset");
    @(posedge clk);
    #2 check("pre_reset_value", dout, 28000);
    #1 rst = 1'b0;
    #1 check("async_reset", dout, 0);
    din = 16'sd1000;
    @(posedge clk);
    #1 check("reset_ignores_din", dout, 0);
    @(negedge clk);
    step(1000, 24, "step_after_reset");
`ifdef FIR_CE_EN
    reset_dut();
    begin
      int j = 0;
      for (int i = 0; i < 46; i++) begin
        @(negedge clk);
        rst = 1'b1;
        din = 16'sd1;
        ce = (i % 2 == 0);
        if (ce) j++;
        q.push_back(exp_t'{1'b1, step_exp(1, j - 1), "ce_step"});
      end
      @(negedge clk);
      ce = 1'b1;
    end
`endif
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_fir.md
Name: pipelined_fir

Overview:
- Fixed-coefficient, fully pipelined transposed-form FIR filter for a 16-bit signed sample stream.
- Accepts one sample every clock and produces one full-precision 64-bit signed output every clock.
- Sits between the sample source (memory/ADC feed) and downstream DSP stages.
- No handshake; the stream is continuous.

Parameters:
- NTAPS, 16, number of filter taps (2..64).
- DIN_W, 16, input sample width, signed.
- COEF_W, 16, coefficient width, signed.
- DOUT_W, 64, output width, signed; must be ≥ DIN_W+COEF_W+clog2(NTAPS).
- COEFFS, {1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1}, packed NTAPS×COEF_W signed coefficients h[0..NTAPS-1].
  - h[0] is in the least-significant slice.
  - Default coefficient sum = 72.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  DIN_W  signed input sample, sampled every rising edge.
- dout  output  DOUT_W  signed filter output, registered.

Behaviour:
- Transfer function: y[n] = sum over k=0..NTAPS-1 of h[k]·x[n-k].
  - x[n] is din sampled at rising edge n.
  - Samples before reset release count as 0.
- Pipeline, fixed LATENCY = 3 regardless of NTAPS:
  - Stage 1: din registered into x_r.
  - Stage 2: NTAPS products p[k] = h[k]·x_r registered, each COEF_W+DIN_W bits signed.
  - Stage 3: transposed accumulator chain, acc[NTAPS-1] <= p[NTAPS-1] and acc[k] <= acc[k+1] + p[k].
  - dout is acc[0].
  - y[n] appears on dout after rising edge n+3 and holds for one cycle.
- Arithmetic:
  - All operands are signed.
  - Products are sign-extended to DOUT_W before accumulation.
  - No rounding, truncation or saturation; with the defaults overflow is impossible.
- Reset:
  - When rst=0, x_r, all p[k], all acc[k] and dout clear to 0 immediately, without waiting for a clock edge.
  - While rst=0, din is ignored.
  - On the first rising edge with rst=1, din is sampled as x[0]; the history is all zeros.
  - Reset asserted mid-stream discards all in-flight samples. Outputs after release depend only on post-release inputs.
- Throughput: one sample in and one result out per cycle, with no stalls (unless the optional feature below is enabled).
- Startup: dout=0 for the first 3 edges after reset release. This is consistent with zero history.

Optional Feature:
- Macro: FIR_CE_EN.
- When defined:
  - Adds input port ce (1 bit), placed after rst.
  - When ce=0, every pipeline register (x_r, p[k], acc[k]) holds its value and din is not sampled. dout is frozen.
  - When ce=1, behaviour is as above.
  - Latency counts only edges with ce=1.
  - Reset overrides ce.
- When undefined:
  - No ce port; the pipeline advances every edge.

Test Plan:
- Impulse: din=1 for one cycle after reset release, else 0.
  - Expect dout = 1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1, starting exactly 3 edges after the impulse is sampled, then 0 forever.
- Step: din=1 continuously from reset release.
  - Expect dout = 0,0,0, then 1,3,6,10,15,21,28,36,44,51,57,62,66,69,71,72, then constant 72.
- Extremes:
  - din=32767 constant settles at dout=2359224.
  - Impulse of din=-32768 gives dout=-32768·h[k], i.e. -32768, -65536, … , -262144 peak, with full 64-bit sign extension.
- Alternating: din = +100, -100, +100, … continuous.
  - After the 19-cycle fill, dout settles to 0 every cycle.
- Reset mid-operation: during a step of din=1000, pull rst low asynchronously between edges.
  - Expect dout=0 immediately, before the next edge.
  - After release with din=1000, dout repeats the step ramp from 0: 0,0,0,1000,3000,… settling at 72000.
- FIR_CE_EN build: step din=1 with ce toggling 1,0,1,0,…
  - Expect dout to change only after ce=1 edges.
  - The sequence of distinct values equals the step test sequence.
  - dout is held during ce=0 cycles.
